priority_encoder_q: RTL and testbench
=====================================

// Module: priority_encoder_q
// PURPOSE
//  Parametrised, clocked successor to the combinational 8-to-3 priority encoder.
//  Latches request bits into a sticky pending register.
//  Issues one encoded index per valid/ready handshake, using fixed or round-robin priority.
//  Sits between interrupt/event sources and a single consumer (e.g. a service FSM).
//  Removes the high-impedance "no request" output: an empty state is signalled by valid=0.
// PARAMETERS
//  N     8           number of request lines, 2..64
//  W     $clog2(N)   width of encoded index y
//  MODE  0           0 = fixed priority (highest index wins); 1 = round robin
// PORTS
//  clk    in   1   clock, rising edge
//  rst    in   1   synchronous, active-high reset
//  en     in   1   grant enable; 0 = no new grant is issued
//  req    in   N   request lines, level or single-cycle pulse, OR-ed into pending
//  ready  in   1   consumer accepts y this cycle when valid=1
//  valid  out  1   y holds a granted index
//  y      out  W   granted index, registered
//  pend   out  N   pending register, for status readback
// BEHAVIOUR
//  - Reset (rst=1 at edge): pend=0, valid=0, y=0, rr pointer g=0. Reset overrides all other inputs.
//  - Pending update each edge: pend <= (pend & ~clr) | req.
//    clr is one-hot(y) when valid&&ready, else 0.
//    req wins over clr: a same-cycle re-request of bit y stays pending.
//  - Candidate set C = pend & ~clr, taken from the current register value.
//    req arriving this cycle is not a candidate; it becomes one next cycle.
//  - Selection over C:
//    MODE=0: highest set index.
//    MODE=1: search order g-1, g-2, ..., 0, N-1, ..., g (mod N); first set bit wins.
//    At reset (g=0) the MODE=1 order equals the fixed order.
//  - FSM with 2 states:
//    IDLE (valid=0):
//      en && C!=0 -> y<=sel, valid<=1, g<=sel, go HOLD.
//      Otherwise stay; y holds its last value.
//    HOLD (valid=1): y and valid are stable until ready=1.
//      ready && en && C!=0 -> y<=sel, g<=sel, stay HOLD. Back-to-back grant, 1 per cycle.
//      ready && !(en && C!=0) -> valid<=0, go IDLE.
//      !ready -> hold. en=0 never revokes an issued grant.
//  - Latency: req at edge k -> pend bit set after k -> valid/y after edge k+1 (2 edges), if idle and en=1.
//  - No outstanding requests: valid=0. y is never X or Z after reset.
//  - Bits set in pend while en=0 are kept and are served once en returns to 1.
//  - Single index: a granted index cannot be re-granted until it has been re-requested after its clear.
// TESTING
//  1. rst=1 for 2 cycles -> valid=0, y=0, pend=0. Hold req=8'hFF during rst -> pend stays 0.
//  2. MODE=0, pulse req=8'b0010_0100, ready=1 -> y=5 then y=2 on consecutive cycles, then valid=0, pend=0.
//  3. MODE=0, ready=0, req=8'h81 -> y=7 held while ready=0. ready=1 for 1 cycle -> y=0 next.
//  4. MODE=1, req=8'hFF held high, ready=1 -> y sequence 7,6,5,...,0,7 (wrap).
//     pend stays 8'hFF because req wins over clr.
//  5. en=0, pulse req=8'h10 -> valid stays 0, pend=8'h10. en=1 -> valid=1, y=4 after 1 edge.
//  6. Grant y=3 outstanding (valid=1, ready=0), assert rst for 1 cycle -> valid=0, y=0, pend=0, g=0.
//     Behaviour after rst deasserts matches test 1.

Source files
------------

// File: rtl/priority_encoder_q.sv
// Clocked priority encoder: sticky pending register, fixed or round-robin selection,
// one encoded index issued per valid/ready handshake.
module priority_encoder_q #(
   parameter int N    = 8,
   parameter int W    = $clog2(N),
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] y,
   output logic [N-1:0] pend
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] y_q, y_d;
   logic [W-1:0] g_q, g_d;
   logic [N-1:0] pend_q, pend_d;
   logic [N-1:0] clr;
   logic [N-1:0] cand;
   logic [W-1:0] sel;
   logic         sel_found;

   function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
      logic [N-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Returns {found, index}. Round robin starts just below the last grant g and wraps,
   // so with g=0 the order degenerates to the fixed highest-index-first order.
   function automatic logic [W:0] pick(input logic [N-1:0] c, input logic [W-1:0] g);
      logic         found;
      logic [W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         int k;
         if (MODE == 0) begin
            k = N - 1 - i;
         end else begin
            k = int'(g) - 1 - i;
            if (k < 0) k = k + N;
         end
         if (!found && c[k]) begin
            found = 1'b1;
            idx   = W'(k);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      g_d     = g_q;
      clr     = (state_q == HOLD && ready) ? onehot(y_q) : '0;
      cand    = pend_q & ~clr;
      {sel_found, sel} = pick(cand, g_q);
      // New requests are OR-ed after the clear so a same-cycle re-request survives.
      pend_d  = cand | req;
      case (state_q)
         IDLE: begin
            if (en && sel_found) begin
               y_d     = sel;
               g_d     = sel;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (ready) begin
               if (en && sel_found) begin
                  y_d = sel;
                  g_d = sel;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         g_q     <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         g_q     <= g_d;
         pend_q  <= pend_d;
      end
   end

   assign valid = (state_q == HOLD);
   assign y     = y_q;
   assign pend  = pend_q;

endmodule

// File: tb/tb_priority_encoder_q.sv
// Directed bench for priority_encoder_q: fixed-priority and round-robin instances
// share stimulus; expected outputs are queued per cycle and compared after each edge.
module tb_priority_encoder_q;

   logic       clk;
   logic       rst;
   logic       en;
   logic       ready;
   logic [7:0] req;
   logic       v0, v1;
   logic [2:0] y0, y1;
   logic [7:0] p0, p1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      bit         inst;
      logic       v;
      logic [2:0] y;
      logic [7:0] p;
   } exp_t;

   exp_t sb[$];

   priority_encoder_q #(.N(8), .W(3), .MODE(0)) dut_fixed (
      .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
      .valid(v0), .y(y0), .pend(p0)
   );

   priority_encoder_q #(.N(8), .W(3), .MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
      .valid(v1), .y(y1), .pend(p1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_out(input string tag, input bit inst, input logic v,
                             input logic [2:0] yy, input logic [7:0] pp);
      exp_t e;
      e.tag  = tag;
      e.inst = inst;
      e.v    = v;
      e.y    = yy;
      e.p    = pp;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t       e;
      logic       ov;
      logic [2:0] oy;
      logic [7:0] op;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         ov = e.inst ? v1 : v0;
         oy = e.inst ? y1 : y0;
         op = e.inst ? p1 : p0;
         checks++;
         assert (ov === e.v) else begin
            errors++;
            $error("FAIL %s valid: got %b expected %b", e.tag, ov, e.v);
         end
         checks++;
         assert (oy === e.y) else begin
            errors++;
            $error("FAIL %s y: got %0d expected %0d", e.tag, oy, e.y);
         end
         checks++;
         assert (op === e.p) else begin
            errors++;
            $error("FAIL %s pend: got %h expected %h", e.tag, op, e.p);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 1'b1; ready = 1'b1; req = 8'hFF;

      // reset with requests held high
      expect_out("t1 rst0", 0, 1'b0, 3'd0, 8'h00); tick();
      expect_out("t1 rst1", 0, 1'b0, 3'd0, 8'h00); tick();
      rst = 1'b0; req = 8'h00;
      expect_out("t1 post", 0, 1'b0, 3'd0, 8'h00); tick();

      // fixed priority, two pulses drained back to back
      req = 8'b0010_0100;
      expect_out("t2 latch", 0, 1'b0, 3'd0, 8'h24); tick();
      req = 8'h00;
      expect_out("t2 y5", 0, 1'b1, 3'd5, 8'h24); tick();
      expect_out("t2 y2", 0, 1'b1, 3'd2, 8'h04); tick();
      expect_out("t2 empty", 0, 1'b0, 3'd2, 8'h00); tick();

      // grant held while ready is low
      ready = 1'b0; req = 8'h81;
      expect_out("t3 latch", 0, 1'b0, 3'd2, 8'h81); tick();
      req = 8'h00;
      expect_out("t3 y7", 0, 1'b1, 3'd7, 8'h81); tick();
      expect_out("t3 hold7", 0, 1'b1, 3'd7, 8'h81); tick();
      ready = 1'b1;
      expect_out("t3 y0", 0, 1'b1, 3'd0, 8'h01); tick();
      ready = 1'b0;
      expect_out("t3 hold0", 0, 1'b1, 3'd0, 8'h01); tick();
      ready = 1'b1;
      expect_out("t3 empty", 0, 1'b0, 3'd0, 8'h00); tick();

      // round robin with all requests held high
      rst = 1'b1;
      expect_out("t4 rst", 1, 1'b0, 3'd0, 8'h00); tick();
      rst = 1'b0; req = 8'hFF;
      expect_out("t4 fill", 1, 1'b0, 3'd0, 8'hFF); tick();
      for (int i = 0; i < 9; i++) begin
         logic [2:0] ey;
         ey = 3'(7 - i);
         expect_out("t4 rr", 1, 1'b1, ey, 8'hFF);
         tick();
      end

      rst = 1'b1; req = 8'h00;
      expect_out("t5 rst", 0, 1'b0, 3'd0, 8'h00); tick();
      rst = 1'b0;

      // requests kept while grants are disabled
      en = 1'b0; req = 8'h10;
      expect_out("t5 latch", 0, 1'b0, 3'd0, 8'h10); tick();
      req = 8'h00;
      expect_out("t5 en0", 0, 1'b0, 3'd0, 8'h10); tick();
      en = 1'b1;
      expect_out("t5 y4", 0, 1'b1, 3'd4, 8'h10); tick();
      expect_out("t5 empty", 0, 1'b0, 3'd4, 8'h00); tick();

      // reset while a grant is outstanding
      ready = 1'b0; req = 8'h08;
      expect_out("t6 latch", 0, 1'b0, 3'd4, 8'h08); tick();
      req = 8'h00;
      expect_out("t6 y3", 0, 1'b1, 3'd3, 8'h08); tick();
      rst = 1'b1;
      expect_out("t6 rst", 0, 1'b0, 3'd0, 8'h00);
      expect_out("t6 rst rr", 1, 1'b0, 3'd0, 8'h00); tick();
      rst = 1'b0;
      expect_out("t6 post", 0, 1'b0, 3'd0, 8'h00); tick();
      // round-robin pointer must be back at 0: index 7 wins over 0
      req = 8'h81;
      expect_out("t6 latch rr", 1, 1'b0, 3'd0, 8'h81); tick();
      req = 8'h00;
      expect_out("t6 fixed y7", 0, 1'b1, 3'd7, 8'h81);
      expect_out("t6 rr y7", 1, 1'b1, 3'd7, 8'h81); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
